// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state type and iteration count.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_e;

  // One radix-2 step per operand bit.
  function automatic int unsigned iter_count(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/result bundle of the iterative multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, flush, op, a, b,
                  input  busy, done, div0, hi, lo);
  modport slave  (input  start, flush, op, a, b,
                  output busy, done, div0, hi, lo);
endinterface

// File: rtl/mdu_addsub.sv
// WIDTH+1-bit adder/subtractor shared by shift-add multiply and
// restoring divide; cout=1 on subtract means no borrow.
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] res,
  output logic           cout
);
  logic [WIDTH+1:0] sum;

  assign sum  = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(WIDTH+1){1'b0}}, sub};
  assign res  = sum[WIDTH:0];
  assign cout = sum[WIDTH+1];
endmodule

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide unit with fixed WIDTH+2 cycle latency,
// signed/unsigned ops, flush and divide-by-zero reporting.
module iter_muldiv
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         rst_n,
  iter_muldiv_if.slave bus
);
  state_e                 state, state_nx;
  op_e                    op_q;
  logic [2*WIDTH:0]       acc, acc_nx;
  logic [WIDTH-1:0]       opb_q;
  logic                   neg_q, rneg_q;
  logic [CNT_W-1:0]       cnt;
  logic                   load, step, fin;

  logic                   is_div, is_div_in, is_signed_in, sa, sb;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         as_x, as_y, as_res;
  logic                   as_sub, as_cout;
  logic [2*WIDTH-1:0]     prod_s;
  logic [WIDTH:0]         rem_s;
  logic [WIDTH-1:0]       quo_s, res_hi, res_lo;
  logic                   dz;

  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Flush outranks both stepping and the FINISH write-back.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    unique case (state)
      S_IDLE:
        if (bus.start && !bus.flush) begin
          load     = 1'b1;
          state_nx = S_CALC;
        end
      S_CALC:
        if (bus.flush) state_nx = S_IDLE;
        else begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) state_nx = S_FINISH;
        end
      S_FINISH: begin
        state_nx = S_IDLE;
        fin      = !bus.flush;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    is_signed_in = (op_e'(bus.op) == OP_MULT) || (op_e'(bus.op) == OP_DIV);
    is_div_in    = (op_e'(bus.op) == OP_DIVU) || (op_e'(bus.op) == OP_DIV);
    sa           = is_signed_in && bus.a[WIDTH-1];
    sb           = is_signed_in && bus.b[WIDTH-1];
    mag_a        = sa ? -bus.a : bus.a;
    mag_b        = sb ? -bus.b : bus.b;
  end

  assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);

  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (as_sub),
    .res  (as_res),
    .cout (as_cout)
  );

  // acc = {upper W+1 bits, lower W bits}: product halves or remainder/quotient.
  always_comb begin
    if (is_div) begin
      as_x   = acc[2*WIDTH-1:WIDTH-1];
      as_y   = {1'b0, opb_q};
      as_sub = 1'b1;
      acc_nx = {(as_cout ? as_res : as_x), acc[WIDTH-2:0], as_cout};
    end else begin
      as_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      as_y   = acc[0] ? {1'b0, opb_q} : '0;
      as_sub = 1'b0;
      acc_nx = {1'b0, as_res, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_s = neg_q  ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_s  = neg_q  ? -acc[WIDTH-1:0]   : acc[WIDTH-1:0];
    rem_s  = rneg_q ? -acc[2*WIDTH:WIDTH] : acc[2*WIDTH:WIDTH];
    dz     = is_div && (opb_q == '0);
    res_hi = is_div ? rem_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    res_lo = dz ? '1 : (is_div ? quo_s : prod_s[WIDTH-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opb_q    <= '0;
      op_q     <= OP_MULTU;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt      <= '0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
      if (load) begin
        op_q   <= op_e'(bus.op);
        neg_q  <= sa ^ sb;
        rneg_q <= sa;
        opb_q  <= is_div_in ? mag_b : mag_a;
        acc    <= {{(WIDTH+1){1'b0}}, (is_div_in ? mag_a : mag_b)};
        cnt    <= CNT_W'(iter_count(WIDTH));
      end else if (step) begin
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
      end else if (fin) begin
        bus.hi   <= res_hi;
        bus.lo   <= res_lo;
        bus.done <= 1'b1;
        bus.div0 <= dz;
      end
    end
  end
endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: directed corner cases, control
// scenarios and random ops against an arithmetic reference model.
module tb_iter_muldiv;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on 64-bit values, no iteration.
  task automatic model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      OP_DIVU:
        if (b == 0) begin hi = a; lo = '1; dz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      default:
        if (b == 0) begin hi = a; lo = '1; dz = 1'b1; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end
    endcase
  endtask

  // Counts edges (continuing from k0) until done is seen, bounded.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus.done && k < 100);
  endtask

  task automatic drive_start(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] ehi, elo;
    logic         edz;
    int           k;
    model(op, a, b, ehi, elo, edz);
    drive_start(op, a, b);
    wait_done(0, k);
    check({tag, "_lat"}, 64'(k), 64'(W + 1));
    check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    check({tag, "_div0"}, 64'(bus.div0), 64'(edz));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ehi, elo, phi, plo;
    logic         edz;
    int           k, seen;
    op_e          rop;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_div0", 64'(bus.div0), 64'(0));
    check("rst_hi",   64'(bus.hi),   64'(0));
    check("rst_lo",   64'(bus.lo),   64'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, "mult_neg");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, "mult_minmin");
    run_op(OP_DIVU,  32'd100,      32'd7,        "divu");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        "div_neg");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    run_op(OP_DIVU,  32'd5,        32'd0,        "divu_zero");
    run_op(OP_DIV,   32'hFFFFFFF0, 32'd0,        "div_zero_neg");
    run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, "div_pos_neg");

    // Start while busy is ignored.
    model(OP_MULTU, 32'd1234, 32'd5678, ehi, elo, edz);
    drive_start(OP_MULTU, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1;
    bus.op = OP_DIVU; bus.a = 32'd99; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_mid", 64'(bus.busy), 64'(1));
    wait_done(10, k);
    check("ign_lat", 64'(k), 64'(W + 1));
    check("ign_lo",  64'(bus.lo), 64'(elo));

    // Back-to-back: start accepted in the done cycle.
    model(OP_DIV, 32'hFFFFFF9C, 32'd9, ehi, elo, edz);
    bus.op = OP_DIV; bus.a = 32'hFFFFFF9C; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(0, k);
    check("b2b_lat", 64'(k), 64'(W + 1));
    check("b2b_hi",  64'(bus.hi), 64'(ehi));
    check("b2b_lo",  64'(bus.lo), 64'(elo));
    phi = bus.hi; plo = bus.lo;

    // Flush at step 10.
    drive_start(OP_MULTU, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
    check("flush_nodone", 64'(seen), 64'(0));
    check("flush_hi", 64'(bus.hi), 64'(phi));
    check("flush_lo", 64'(bus.lo), 64'(plo));

    // Flush on the FINISH edge beats completion.
    drive_start(OP_DIVU, 32'd1000, 32'd3);
    repeat (W) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flfin_done", 64'(bus.done), 64'(0));
    check("flfin_busy", 64'(bus.busy), 64'(0));
    check("flfin_lo",   64'(bus.lo),   64'(plo));

    // Flush together with start in IDLE drops the start.
    @(negedge clk);
    bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush_start", 64'(bus.busy), 64'(0));

    // Reset at step 20.
    drive_start(OP_MULT, 32'hFFFF0000, 32'h00010001);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_hi",   64'(bus.hi),   64'(0));
    check("arst_lo",   64'(bus.lo),   64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) seen++; end
    check("arst_nodone", 64'(seen), 64'(0));
    run_op(OP_DIVU, 32'd77, 32'd10, "post_rst");

    // Random ops.
    for (int i = 0; i < 30; i++) begin
      rop = op_e'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'h80000000;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_op(rop, ra, rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (even, at least 4).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 flush  input  1  synchronous abort of an operation in progress.
REQ-007 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-008 a  input  WIDTH  multiplicand or dividend; captured with start.
REQ-009 b  input  WIDTH  multiplier or divisor; captured with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 div0  output  1  valid with done; high when a divide had b==0.
REQ-013 hi  output  WIDTH  product upper half, or remainder.
REQ-014 lo  output  WIDTH  product lower half, or quotient.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and FINISH.
REQ-016 In IDLE, start=1 at a clock edge (edge 0) SHALL capture op/a/b, load the counter with WIDTH, set busy and enter CALC.
REQ-017 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; the counter decrements per step; after the WIDTH-th step (edge WIDTH) the FSM enters FINISH.
REQ-018 In FINISH (edge WIDTH+1) the block SHALL apply sign correction, write hi/lo, pulse done and div0, clear busy and return to IDLE.
REQ-019 Fixed latency: done is high in the cycle after edge WIDTH+1, for exactly one cycle, independent of operand values.
REQ-020 hi/lo SHALL change only at the FINISH edge and otherwise hold the last result.
REQ-021 Signed ops SHALL operate on magnitudes; product negated over 2*WIDTH bits when operand signs differ; quotient negated when signs differ; remainder takes the dividend's sign.
REQ-022 Magnitude of the most-negative value SHALL be handled as unsigned 2^(WIDTH-1) without overflow.
REQ-023 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, div0 = 0.
REQ-024 Divide with b==0 SHALL still take full latency and give hi = a, lo = all ones, div0 = 1.
REQ-025 start while busy SHALL be ignored; no queuing.
REQ-026 start in the cycle done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-027 flush=1 in CALC or FINISH SHALL return to IDLE at that edge, clear busy, suppress done, and leave hi/lo unchanged; flush has priority over FINISH completion.
REQ-028 flush in IDLE SHALL have no effect; flush and start together in IDLE SHALL drop the start.

Reset
REQ-029 rst_n low SHALL immediately force the FSM to IDLE and set busy=0, done=0, div0=0, hi=0, lo=0, and the counter and internal operand registers to 0.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse; the first start accepted after reset release SHALL behave normally.

Structure
REQ-031 The op encodings, the FSM state type and a function giving iteration count from WIDTH SHALL live in shared package mdu_pkg.
REQ-032 The WIDTH+1-bit add/subtract datapath used by both algorithms SHALL be the single sub-module mdu_addsub.
REQ-033 The datapath SHALL use one shared accumulator register of 2*WIDTH+1 bits for product/remainder-quotient, with no combinational path from a/b to hi/lo.

Verification (WIDTH=32)
REQ-034 MULTU a=FFFFFFFF b=FFFFFFFF -> done after 34 edges, hi=FFFFFFFE, lo=00000001, div0=0.
REQ-035 MULT a=FFFFFFFD (-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1.
REQ-036 DIVU a=100 b=7 -> lo=14, hi=2; DIV a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-037 DIVU a=5 b=0 -> hi=5, lo=FFFFFFFF, div0=1, latency unchanged.
REQ-038 start at cycle 0 and again at cycle 10 -> second start ignored; back-to-back start in the done cycle -> second result 34 edges later.
REQ-039 flush at CALC step 10, and separately rst_n low at step 20 -> busy drops, no done, hi/lo keep prior value (flush) or become 0 (reset).
